// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU result stage and its select logic.
//   - opcode constants for the operations the result stage understands
//   - state encoding of the 2-entry skid buffer
//   - the result-entry record held in the main and skid registers
package alu_pkg;

   // Width of the entry record. alu_result_stage is only ever built with its
   // WIDTH parameter equal to this value.
   localparam int ALU_WIDTH    = 32;
   localparam int ALU_OPCODE_W = 5;

   localparam logic [ALU_OPCODE_W-1:0] OP_ADD = 5'b00000;
   localparam logic [ALU_OPCODE_W-1:0] OP_SUB = 5'b00001;
   localparam logic [ALU_OPCODE_W-1:0] OP_AND = 5'b00010;
   localparam logic [ALU_OPCODE_W-1:0] OP_OR  = 5'b00011;
   localparam logic [ALU_OPCODE_W-1:0] OP_SLL = 5'b00100;
   localparam logic [ALU_OPCODE_W-1:0] OP_SRA = 5'b00101;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } stage_state_e;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] data;
      logic                 overflow;
      logic                 neq;
      logic                 lt;
      logic                 illegal;
   } alu_entry_t;

endpackage

// File: rtl/alu_result_select.sv
// alu_result_select: purely combinational opcode mux and flag derivation.
// Ports:
//   ctrl_ALUopcode         operation select
//   *_result, *_overflow   outputs of the AND/OR, add/sub and shift units
//   entry                  selected result plus overflow/neq/lt/illegal flags
module alu_result_select
   import alu_pkg::*;
#(
   parameter int WIDTH    = ALU_WIDTH,
   parameter int OPCODE_W = ALU_OPCODE_W
) (
   input  logic [OPCODE_W-1:0] ctrl_ALUopcode,
   input  logic [WIDTH-1:0]    and_result,
   input  logic [WIDTH-1:0]    or_result,
   input  logic [WIDTH-1:0]    add_result,
   input  logic                add_overflow,
   input  logic [WIDTH-1:0]    sub_result,
   input  logic                sub_overflow,
   input  logic [WIDTH-1:0]    sll_result,
   input  logic [WIDTH-1:0]    sra_result,
   output alu_entry_t          entry
);

   alu_entry_t entry_s;

   // Opcode mux; compare flags come from the subtractor for every opcode.
   always_comb begin
      entry_s          = '0;
      entry_s.neq      = (sub_result != {WIDTH{1'b0}});
      // Signed less-than: the sign of A-B is wrong exactly when it overflowed.
      entry_s.lt       = sub_result[WIDTH-1] ^ sub_overflow;
      case (ctrl_ALUopcode)
         OP_ADD: begin
            entry_s.data     = add_result;
            entry_s.overflow = add_overflow;
         end
         OP_SUB: begin
            entry_s.data     = sub_result;
            entry_s.overflow = sub_overflow;
         end
         OP_AND: entry_s.data = and_result;
         OP_OR:  entry_s.data = or_result;
         OP_SLL: entry_s.data = sll_result;
         OP_SRA: entry_s.data = sra_result;
         default: begin
            entry_s.data     = {WIDTH{1'b0}};
            entry_s.overflow = 1'b0;
            entry_s.illegal  = 1'b1;
         end
      endcase
   end

   assign entry = entry_s;

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered ALU result stage with a 2-entry skid buffer.
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready depends on state only)
//   ctrl_ALUopcode      operation select
//   *_result/_overflow  unit outputs feeding the result mux
//   out_valid/out_ready downstream handshake
//   data_result, overflow, isNotEqual, isLessThan, illegal_op
//                       head-of-queue entry, always taken from the main register
//   retire_count        wrapping count of drained operations
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int OPCODE_W = 5,
   parameter int COUNT_W  = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OPCODE_W-1:0] ctrl_ALUopcode,
   input  logic [WIDTH-1:0]    and_result,
   input  logic [WIDTH-1:0]    or_result,
   input  logic [WIDTH-1:0]    add_result,
   input  logic                add_overflow,
   input  logic [WIDTH-1:0]    sub_result,
   input  logic                sub_overflow,
   input  logic [WIDTH-1:0]    sll_result,
   input  logic [WIDTH-1:0]    sra_result,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    data_result,
   output logic                overflow,
   output logic                isNotEqual,
   output logic                isLessThan,
   output logic                illegal_op,
   output logic [COUNT_W-1:0]  retire_count
);

   stage_state_e       state_r;
   stage_state_e       state_next_s;
   alu_entry_t         new_entry_s;
   alu_entry_t         main_r;
   alu_entry_t         skid_r;
   logic               accept_s;
   logic               drain_s;
   logic               load_main_new_s;
   logic               load_main_skid_s;
   logic               load_skid_s;
   logic [COUNT_W-1:0] retire_count_r;

   alu_result_select #(
      .WIDTH    (WIDTH),
      .OPCODE_W (OPCODE_W)
   ) u_select (
      .ctrl_ALUopcode (ctrl_ALUopcode),
      .and_result     (and_result),
      .or_result      (or_result),
      .add_result     (add_result),
      .add_overflow   (add_overflow),
      .sub_result     (sub_result),
      .sub_overflow   (sub_overflow),
      .sll_result     (sll_result),
      .sra_result     (sra_result),
      .entry          (new_entry_s)
   );

   assign accept_s = in_valid & in_ready;
   assign drain_s  = out_valid & out_ready;

   // State register of the skid buffer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and entry-load decode.
   always_comb begin
      state_next_s     = state_r;
      load_main_new_s  = 1'b0;
      load_main_skid_s = 1'b0;
      load_skid_s      = 1'b0;
      case (state_r)
         EMPTY: begin
            if (accept_s) begin
               state_next_s    = ONE;
               load_main_new_s = 1'b1;
            end else begin
               state_next_s = EMPTY;
            end
         end
         ONE: begin
            if (accept_s && drain_s) begin
               state_next_s    = ONE;
               load_main_new_s = 1'b1;
            end else if (accept_s) begin
               state_next_s = FULL;
               load_skid_s  = 1'b1;
            end else if (drain_s) begin
               state_next_s = EMPTY;
            end else begin
               state_next_s = ONE;
            end
         end
         FULL: begin
            // in_ready is low here, so only a drain can move the state.
            if (drain_s) begin
               state_next_s     = ONE;
               load_main_skid_s = 1'b1;
            end else begin
               state_next_s = FULL;
            end
         end
         default: begin
            state_next_s = EMPTY;
         end
      endcase
   end

   // Handshake outputs decoded from the state flop only.
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      case (state_r)
         EMPTY: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
         ONE: begin
            in_ready  = 1'b1;
            out_valid = 1'b1;
         end
         FULL: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
      endcase
   end

   // Main (head) and skid entry registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_r <= '0;
         skid_r <= '0;
      end else begin
         if (load_main_new_s) begin
            main_r <= new_entry_s;
         end else if (load_main_skid_s) begin
            main_r <= skid_r;
         end else begin
            main_r <= main_r;
         end
         if (load_skid_s) begin
            skid_r <= new_entry_s;
         end else begin
            skid_r <= skid_r;
         end
      end
   end

   // Retired-operation counter; wraps naturally at all-ones.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         retire_count_r <= {COUNT_W{1'b0}};
      end else if (drain_s) begin
         retire_count_r <= retire_count_r + COUNT_W'(1);
      end else begin
         retire_count_r <= retire_count_r;
      end
   end

   assign data_result  = main_r.data;
   assign overflow     = main_r.overflow;
   assign isNotEqual   = main_r.neq;
   assign isLessThan   = main_r.lt;
   assign illegal_op   = main_r.illegal;
   assign retire_count = retire_count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  ctrl_ALUopcode;
   logic [31:0] and_result, or_result, add_result, sub_result, sll_result, sra_result;
   logic        add_overflow, sub_overflow;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_result;
   logic        overflow, isNotEqual, isLessThan, illegal_op;
   logic [15:0] retire_count;

   int checks   = 0;
   int failures = 0;
   int exp_count = 0;
   int needed;

   alu_result_stage #(.WIDTH(32), .OPCODE_W(5), .COUNT_W(16)) dut (
      .clock          (clock),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .ctrl_ALUopcode (ctrl_ALUopcode),
      .and_result     (and_result),
      .or_result      (or_result),
      .add_result     (add_result),
      .add_overflow   (add_overflow),
      .sub_result     (sub_result),
      .sub_overflow   (sub_overflow),
      .sll_result     (sll_result),
      .sra_result     (sra_result),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .data_result    (data_result),
      .overflow       (overflow),
      .isNotEqual     (isNotEqual),
      .isLessThan     (isLessThan),
      .illegal_op     (illegal_op),
      .retire_count   (retire_count)
   );

   always #5 clock = ~clock;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_op(input logic [4:0] op, input logic [31:0] v_and, input logic [31:0] v_or,
                         input logic [31:0] v_add, input logic v_addov, input logic [31:0] v_sub,
                         input logic v_subov, input logic [31:0] v_sll, input logic [31:0] v_sra);
      ctrl_ALUopcode = op;
      and_result     = v_and;
      or_result      = v_or;
      add_result     = v_add;
      add_overflow   = v_addov;
      sub_result     = v_sub;
      sub_overflow   = v_subov;
      sll_result     = v_sll;
      sra_result     = v_sra;
   endtask

   // Accept one op into an empty stage; it is then visible on the outputs.
   task automatic send_one();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Let the held op drain and check the counter and empty state.
   task automatic drain_one(input string tag);
      tick();
      exp_count = (exp_count + 1) % 65536;
      chk32({tag, "_cnt"}, {16'd0, retire_count}, 32'(exp_count));
      chk1({tag, "_empty"}, out_valid, 1'b0);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_op(5'b00000, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk32("rst_data", data_result, 32'd0);
      chk32("rst_count", {16'd0, retire_count}, 32'd0);

      // AND
      set_op(5'b00010, 32'h0000F0F0, 32'hAAAA0000, 32'h1234, 1'b1, 32'h5, 1'b0, 32'h1, 32'h2);
      send_one();
      chk1("and_valid", out_valid, 1'b1);
      chk32("and_data", data_result, 32'h0000F0F0);
      chk1("and_ovf", overflow, 1'b0);
      chk1("and_illegal", illegal_op, 1'b0);
      drain_one("and");

      // SUB compares
      set_op(5'b00001, 32'h0, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFE, 1'b0, 32'h0, 32'h0);
      send_one();
      chk32("sub1_data", data_result, 32'hFFFFFFFE);
      chk1("sub1_lt", isLessThan, 1'b1);
      chk1("sub1_neq", isNotEqual, 1'b1);
      chk1("sub1_ovf", overflow, 1'b0);
      drain_one("sub1");
      set_op(5'b00001, 32'h0, 32'h0, 32'h0, 1'b0, 32'h80000000, 1'b1, 32'h0, 32'h0);
      send_one();
      chk1("sub2_lt", isLessThan, 1'b0);
      chk1("sub2_neq", isNotEqual, 1'b1);
      chk1("sub2_ovf", overflow, 1'b1);
      drain_one("sub2");
      set_op(5'b00001, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      send_one();
      chk1("sub3_neq", isNotEqual, 1'b0);
      chk1("sub3_lt", isLessThan, 1'b0);
      drain_one("sub3");

      // Illegal opcode
      set_op(5'b01111, 32'h1, 32'h2, 32'h3, 1'b1, 32'h4, 1'b1, 32'h5, 32'h6);
      send_one();
      chk32("ill_data", data_result, 32'd0);
      chk1("ill_flag", illegal_op, 1'b1);
      chk1("ill_ovf", overflow, 1'b0);
      drain_one("ill");

      // ADD overflow, SLL ignores add_overflow, SRA select
      set_op(5'b00000, 32'h1, 32'h2, 32'h7, 1'b1, 32'h4, 1'b0, 32'h5, 32'h6);
      send_one();
      chk32("add_data", data_result, 32'h7);
      chk1("add_ovf", overflow, 1'b1);
      drain_one("add");
      set_op(5'b00100, 32'h1, 32'h2, 32'h7, 1'b1, 32'h4, 1'b1, 32'h100, 32'h6);
      send_one();
      chk32("sll_data", data_result, 32'h100);
      chk1("sll_ovf", overflow, 1'b0);
      drain_one("sll");
      set_op(5'b00101, 32'h1, 32'h2, 32'h7, 1'b1, 32'h4, 1'b1, 32'h100, 32'hFFFF0000);
      send_one();
      chk32("sra_data", data_result, 32'hFFFF0000);
      chk1("sra_illegal", illegal_op, 1'b0);
      drain_one("sra");

      // Backpressure: X then Y with out_ready low, Z must wait
      out_ready = 1'b0;
      set_op(5'b00000, 32'h0, 32'h0, 32'h11, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      in_valid = 1'b1;
      tick();
      chk1("bp_x_ready", in_ready, 1'b1);
      chk32("bp_x_data", data_result, 32'h11);
      set_op(5'b00011, 32'h0, 32'h22, 32'h99, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      tick();
      chk1("bp_full_ready", in_ready, 1'b0);
      chk32("bp_full_data", data_result, 32'h11);
      set_op(5'b00010, 32'h33, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      chk1("bp_z_blocked", in_ready, 1'b0);
      chk1("bp_hold_valid", out_valid, 1'b1);
      chk32("bp_hold_data", data_result, 32'h11);
      chk32("bp_hold_cnt", {16'd0, retire_count}, 32'(exp_count));
      out_ready = 1'b1;
      tick();
      exp_count++;
      chk32("bp_second", data_result, 32'h22);
      chk1("bp_ready_back", in_ready, 1'b1);
      chk32("bp_cnt1", {16'd0, retire_count}, 32'(exp_count));
      tick();
      exp_count++;
      chk32("bp_z_data", data_result, 32'h33);
      chk1("bp_z_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      drain_one("bp_z");

      // Counter wrap: stream until 0xFFFF drains, then one more
      needed = 65535 - exp_count;
      set_op(5'b00010, 32'h5A5A, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < needed; i++) begin
         tick();
      end
      in_valid = 1'b0;
      tick();
      exp_count = 65535;
      chk32("wrap_max", {16'd0, retire_count}, 32'h0000FFFF);
      chk1("wrap_empty", out_valid, 1'b0);
      send_one();
      drain_one("wrap_zero");
      chk32("wrap_zero_raw", {16'd0, retire_count}, 32'h0);

      // Reset while FULL with out_ready low
      out_ready = 1'b0;
      set_op(5'b00011, 32'h0, 32'h55, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      in_valid = 1'b1;
      tick();
      set_op(5'b01111, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      tick();
      in_valid = 1'b0;
      chk1("pre_rst_full", in_ready, 1'b0);
      chk32("pre_rst_data", data_result, 32'h55);
      #2;
      reset = 1'b1;
      #1;
      chk1("mid_rst_valid", out_valid, 1'b0);
      chk1("mid_rst_ready", in_ready, 1'b1);
      chk32("mid_rst_data", data_result, 32'd0);
      chk32("mid_rst_count", {16'd0, retire_count}, 32'd0);
      chk1("mid_rst_illegal", illegal_op, 1'b0);
      tick();
      reset = 1'b0;
      tick();
      chk1("post_rst_valid", out_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
